// File: rtl/io_port_hub_pkg.sv
// -----------------------------------------------------------------------------
// io_hub_pkg
// Shared definitions for the I/O port hub:
//   - byte offsets of the hub window (input ports, output ports, status word)
//   - converter FSM state encoding
//   - active-low seven-segment patterns (gfedcba) for 0-9 and the dash
//   - pow10 helper used to derive the display overflow limit
// -----------------------------------------------------------------------------
package io_hub_pkg;

  // Hub window layout; bits [1:0] of the bus address are never decoded.
  localparam logic [7:0] IN_BASE   = 8'h00;
  localparam logic [7:0] OUT_BASE  = 8'h40;
  localparam logic [7:0] STAT_ADDR = 8'h7C;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_ZERO = 7'b1000000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_e;

  // Decimal digit to active-low segments; anything outside 0-9 shows a dash.
  function automatic logic [6:0] seg7(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

  // 10^n as a 32-bit value; intended for elaboration-time constants.
  function automatic logic [31:0] pow10(input int unsigned n);
    logic [31:0] r;
    r = 32'd1;
    for (int unsigned k = 0; k < n; k++) begin
      r = r * 32'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_seq_conv.sv
// -----------------------------------------------------------------------------
// bcd_seq_conv
// Sequential binary-to-BCD converter (double dabble) for one display port.
// A load while a conversion is running is parked as "pending"; the running
// conversion finishes without updating the display and the parked value is
// converted next, so only the latest value ever reaches the digits.
// Ports:
//   clk, reset      clock, synchronous active-low reset
//   load            write strobe for this port (same cycle as the bus write)
//   load_val        low CONV_BITS bits of the written value
//   load_ovf        written value does not fit in DIGITS decimal digits
//   busy            conversion in progress (registered)
//   hex             DIGITS active-low digits, digit 0 least significant
// -----------------------------------------------------------------------------
module bcd_seq_conv
  import io_hub_pkg::*;
#(
  parameter int DIGITS    = 2,
  parameter int CONV_BITS = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [CONV_BITS-1:0]   load_val,
  input  logic                   load_ovf,
  output logic                   busy,
  output logic [DIGITS*7-1:0]    hex
);

  localparam int SW = $clog2(CONV_BITS + 1);
  localparam int BW = DIGITS * 4;

  conv_state_e            state_q, state_d;
  logic [CONV_BITS-1:0]   bin_q, bin_d;
  logic [BW-1:0]          bcd_q, bcd_d;
  logic [SW-1:0]          step_q, step_d;
  logic                   ovf_q, ovf_d;
  logic                   pend_q, pend_d;
  logic [CONV_BITS-1:0]   pend_val_q, pend_val_d;
  logic                   pend_ovf_q, pend_ovf_d;
  logic                   busy_q, busy_d;
  logic [DIGITS*7-1:0]    hex_q, hex_d;

  logic [BW-1:0]          bcd_adj_s;
  logic [DIGITS*7-1:0]    disp_s;

  // Add-3 correction on every BCD nibble of 5 or more, ahead of the shift.
  always_comb begin
    bcd_adj_s = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_q[k*4 +: 4] >= 4'd5) begin
        bcd_adj_s[k*4 +: 4] = bcd_q[k*4 +: 4] + 4'd3;
      end else begin
        bcd_adj_s[k*4 +: 4] = bcd_q[k*4 +: 4];
      end
    end
  end

  // Segment image of the finished conversion; an overflowed value shows dashes.
  always_comb begin
    disp_s = {DIGITS{SEG_DASH}};
    for (int d = 0; d < DIGITS; d++) begin
      if (ovf_q) begin
        disp_s[d*7 +: 7] = SEG_DASH;
      end else begin
        disp_s[d*7 +: 7] = seg7(bcd_q[d*4 +: 4]);
      end
    end
  end

  // Converter FSM next-state: IDLE -> SHIFT (CONV_BITS steps) -> DONE -> IDLE/SHIFT.
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    step_d     = step_q;
    ovf_d      = ovf_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    pend_ovf_d = pend_ovf_q;
    busy_d     = busy_q;
    hex_d      = hex_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = SHIFT;
          bin_d   = load_val;
          bcd_d   = {BW{1'b0}};
          step_d  = {SW{1'b0}};
          ovf_d   = load_ovf;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        bcd_d = {bcd_adj_s[BW-2:0], bin_q[CONV_BITS-1]};
        bin_d = {bin_q[CONV_BITS-2:0], 1'b0};
        if (step_q == SW'(CONV_BITS - 1)) begin
          state_d = DONE;
          step_d  = {SW{1'b0}};
        end else begin
          step_d  = step_q + SW'(1);
        end
        // A newer write only replaces the parked value; it never disturbs the run.
        if (load) begin
          pend_d     = 1'b1;
          pend_val_d = load_val;
          pend_ovf_d = load_ovf;
        end else begin
          pend_d     = pend_q;
        end
      end
      DONE: begin
        // A write landing on the DONE edge is newer than anything parked.
        if (load) begin
          state_d = SHIFT;
          bin_d   = load_val;
          bcd_d   = {BW{1'b0}};
          step_d  = {SW{1'b0}};
          ovf_d   = load_ovf;
          pend_d  = 1'b0;
          busy_d  = 1'b1;
        end else if (pend_q) begin
          state_d = SHIFT;
          bin_d   = pend_val_q;
          bcd_d   = {BW{1'b0}};
          step_d  = {SW{1'b0}};
          ovf_d   = pend_ovf_q;
          pend_d  = 1'b0;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
          hex_d   = disp_s;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        pend_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Converter state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      bin_q      <= {CONV_BITS{1'b0}};
      bcd_q      <= {BW{1'b0}};
      step_q     <= {SW{1'b0}};
      ovf_q      <= 1'b0;
      pend_q     <= 1'b0;
      pend_val_q <= {CONV_BITS{1'b0}};
      pend_ovf_q <= 1'b0;
      busy_q     <= 1'b0;
      hex_q      <= {DIGITS{SEG_ZERO}};
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      step_q     <= step_d;
      ovf_q      <= ovf_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      pend_ovf_q <= pend_ovf_d;
      busy_q     <= busy_d;
      hex_q      <= hex_d;
    end
  end

  assign busy = busy_q;
  assign hex  = hex_q;

endmodule

// File: rtl/io_port_hub.sv
// -----------------------------------------------------------------------------
// io_port_hub
// Memory-mapped I/O hub: N_IN debounced switch ports and N_OUT decimal display
// ports behind the CPU data bus.
// Ports:
//   clk, reset   clock, synchronous active-low reset
//   sw           raw switches, port i = sw[i*IN_BITS +: IN_BITS]
//   io_sel/io_we bus select and write strobe
//   io_addr      byte offset in hub window (bits [1:0] ignored)
//   io_wdata     write data
//   io_rdata     combinational read data for io_addr (unmapped -> 0)
//   hex          active-low digits, port j digit d = hex[(j*DIGITS+d)*7 +: 7]
//   busy         per-port conversion in progress
// -----------------------------------------------------------------------------
module io_port_hub
  import io_hub_pkg::*;
#(
  parameter int N_IN      = 2,
  parameter int IN_BITS   = 5,
  parameter int N_OUT     = 3,
  parameter int DIGITS    = 2,
  parameter int CONV_BITS = 7,
  parameter int DEB_CYC   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_IN*IN_BITS-1:0]    sw,
  input  logic                       io_sel,
  input  logic                       io_we,
  input  logic [7:0]                 io_addr,
  input  logic [31:0]                io_wdata,
  output logic [31:0]                io_rdata,
  output logic [N_OUT*DIGITS*7-1:0]  hex,
  output logic [N_OUT-1:0]           busy
);

  localparam int          CW        = $clog2(DEB_CYC + 1);
  localparam logic [31:0] OVF_LIMIT = pow10(DIGITS);

  logic [IN_BITS-1:0] sync1_q  [N_IN];
  logic [IN_BITS-1:0] sync1_d  [N_IN];
  logic [IN_BITS-1:0] sync2_q  [N_IN];
  logic [IN_BITS-1:0] sync2_d  [N_IN];
  logic [IN_BITS-1:0] stable_q [N_IN];
  logic [IN_BITS-1:0] stable_d [N_IN];
  logic [CW-1:0]      cnt_q    [N_IN];
  logic [CW-1:0]      cnt_d    [N_IN];
  logic [31:0]        out_reg_q [N_OUT];
  logic [31:0]        out_reg_d [N_OUT];

  logic               wr_en_s;
  logic               wr_ovf_s;
  logic [N_OUT-1:0]   load_s;
  logic               unused_addr_bits_s;

  assign wr_en_s            = io_sel & io_we;
  assign wr_ovf_s           = (io_wdata >= OVF_LIMIT);
  assign unused_addr_bits_s = ^io_addr[1:0];

  // Two-stage synchroniser and debounce: a change is accepted once it has
  // differed from the stable value for DEB_CYC consecutive cycles.
  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      sync1_d[i] = sw[i*IN_BITS +: IN_BITS];
      sync2_d[i] = sync1_q[i];
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CW'(DEB_CYC - 1)) begin
          stable_d[i] = sync2_q[i];
          cnt_d[i]    = {CW{1'b0}};
        end else begin
          stable_d[i] = stable_q[i];
          cnt_d[i]    = cnt_q[i] + CW'(1);
        end
      end else begin
        stable_d[i] = stable_q[i];
        cnt_d[i]    = {CW{1'b0}};
      end
    end
  end

  // Output-port write decode; the status word address is never a write target.
  always_comb begin
    for (int j = 0; j < N_OUT; j++) begin
      if (wr_en_s && (io_addr[7:2] == (OUT_BASE[7:2] + 6'(j)))
          && (io_addr[7:2] != STAT_ADDR[7:2])) begin
        load_s[j]    = 1'b1;
        out_reg_d[j] = io_wdata;
      end else begin
        load_s[j]    = 1'b0;
        out_reg_d[j] = out_reg_q[j];
      end
    end
  end

  // Read mux: status word, then input ports, then output readback; else zero.
  always_comb begin
    io_rdata = 32'd0;
    if (io_addr[7:2] == STAT_ADDR[7:2]) begin
      io_rdata = {{(32-N_OUT){1'b0}}, busy};
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (io_addr[7:2] == (IN_BASE[7:2] + 6'(i))) begin
          io_rdata = {{(32-IN_BITS){1'b0}}, stable_q[i]};
        end else begin
          io_rdata = io_rdata;
        end
      end
      for (int j = 0; j < N_OUT; j++) begin
        if (io_addr[7:2] == (OUT_BASE[7:2] + 6'(j))) begin
          io_rdata = out_reg_q[j];
        end else begin
          io_rdata = io_rdata;
        end
      end
    end
  end

  // Input path and output value registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N_IN; i++) begin
        sync1_q[i]  <= {IN_BITS{1'b0}};
        sync2_q[i]  <= {IN_BITS{1'b0}};
        stable_q[i] <= {IN_BITS{1'b0}};
        cnt_q[i]    <= {CW{1'b0}};
      end
      for (int j = 0; j < N_OUT; j++) begin
        out_reg_q[j] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        sync1_q[i]  <= sync1_d[i];
        sync2_q[i]  <= sync2_d[i];
        stable_q[i] <= stable_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      for (int j = 0; j < N_OUT; j++) begin
        out_reg_q[j] <= out_reg_d[j];
      end
    end
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_conv
    bcd_seq_conv #(
      .DIGITS    (DIGITS),
      .CONV_BITS (CONV_BITS)
    ) u_conv (
      .clk      (clk),
      .reset    (reset),
      .load     (load_s[j]),
      .load_val (io_wdata[CONV_BITS-1:0]),
      .load_ovf (wr_ovf_s),
      .busy     (busy[j]),
      .hex      (hex[j*DIGITS*7 +: DIGITS*7])
    );
  end

endmodule

// File: tb/tb_io_port_hub.sv
module tb_io_port_hub;

  localparam int N_IN = 2, IN_BITS = 5, N_OUT = 3, DIGITS = 2, CONV_BITS = 7, DEB_CYC = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  sw;
  logic        io_sel, io_we;
  logic [7:0]  io_addr;
  logic [31:0] io_wdata, io_rdata;
  logic [41:0] hex;
  logic [2:0]  busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          port;
    logic [13:0] hex;
  } exp_t;
  exp_t sb_q[$];

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  always #5 clk = ~clk;

  io_port_hub #(
    .N_IN(N_IN), .IN_BITS(IN_BITS), .N_OUT(N_OUT),
    .DIGITS(DIGITS), .CONV_BITS(CONV_BITS), .DEB_CYC(DEB_CYC)
  ) dut (
    .clk(clk), .reset(reset), .sw(sw), .io_sel(io_sel), .io_we(io_we),
    .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata),
    .hex(hex), .busy(busy)
  );

  function automatic logic [13:0] exp_hex(input int v);
    logic [13:0] r;
    if (v >= 100) r = {7'b0111111, 7'b0111111};
    else          r = {seg_tab[v / 10], seg_tab[v % 10]};
    return r;
  endfunction

  function automatic logic [13:0] port_hex(input int p);
    return hex[p*14 +: 14];
  endfunction

  // Caller sits at a negedge; the write is taken on the next posedge.
  task automatic do_write(input logic [7:0] a, input logic [31:0] d);
    io_sel = 1'b1; io_we = 1'b1; io_addr = a; io_wdata = d;
    @(negedge clk);
    io_sel = 1'b0; io_we = 1'b0; io_wdata = 32'd0;
  endtask

  task automatic do_read(input logic [7:0] a, output logic [31:0] d);
    io_addr = a;
    #1;
    d = io_rdata;
  endtask

  task automatic wait_idle(input int p, input int start, input int budget, output int e);
    e = start;
    while (busy[p] === 1'b1 && e < budget) begin
      @(negedge clk);
      e++;
    end
  endtask

  task automatic test_reset;
    logic [31:0] r;
    reset = 1'b0; sw = 10'd0; io_sel = 1'b0; io_we = 1'b0; io_addr = 8'd0; io_wdata = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (hex !== {6{7'b1000000}}) begin errors++; $display("FAIL reset_hex: got %h expected %h", hex, {6{7'b1000000}}); end
    checks++; if (busy !== 3'b000) begin errors++; $display("FAIL reset_busy: got %b expected 000", busy); end
    do_read(8'h40, r); checks++; if (r !== 32'd0) begin errors++; $display("FAIL reset_rd40: got %0h expected 0", r); end
    do_read(8'h44, r); checks++; if (r !== 32'd0) begin errors++; $display("FAIL reset_rd44: got %0h expected 0", r); end
    do_read(8'h48, r); checks++; if (r !== 32'd0) begin errors++; $display("FAIL reset_rd48: got %0h expected 0", r); end
    do_read(8'h00, r); checks++; if (r !== 32'd0) begin errors++; $display("FAIL reset_rd00: got %0h expected 0", r); end
  endtask

  task automatic test_convert;
    logic [31:0] r;
    int e;
    exp_t x;
    do_write(8'h40, 32'd37);
    sb_q.push_back('{0, exp_hex(37)});
    checks++; if (busy[0] !== 1'b1) begin errors++; $display("FAIL conv_busy_hi: got %b expected 1", busy[0]); end
    checks++; if (port_hex(0) !== {2{7'b1000000}}) begin errors++; $display("FAIL conv_hex_early: got %h expected %h", port_hex(0), {2{7'b1000000}}); end
    do_read(8'h40, r); checks++; if (r !== 32'd37) begin errors++; $display("FAIL conv_readback: got %0d expected 37", r); end
    do_read(8'h7C, r); checks++; if (r !== 32'd1) begin errors++; $display("FAIL conv_status: got %0h expected 1", r); end
    wait_idle(0, 0, 40, e);
    x = sb_q.pop_front();
    checks++; if (e !== 8) begin errors++; $display("FAIL conv_latency: got %0d edges expected 8", e); end
    checks++; if (port_hex(x.port) !== x.hex) begin errors++; $display("FAIL conv_hex37: got %h expected %h", port_hex(x.port), x.hex); end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL conv_busy_lo: got %b expected 0", busy[0]); end
  endtask

  task automatic test_overflow;
    logic [31:0] r;
    int e;
    exp_t x;
    do_write(8'h44, 32'd100);
    sb_q.push_back('{1, exp_hex(100)});
    do_read(8'h44, r); checks++; if (r !== 32'd100) begin errors++; $display("FAIL ovf_readback: got %0d expected 100", r); end
    wait_idle(1, 0, 40, e);
    x = sb_q.pop_front();
    checks++; if (e !== 8) begin errors++; $display("FAIL ovf_latency: got %0d edges expected 8", e); end
    checks++; if (port_hex(x.port) !== x.hex) begin errors++; $display("FAIL ovf_dash: got %h expected %h", port_hex(x.port), x.hex); end
    checks++; if (port_hex(0) !== exp_hex(37)) begin errors++; $display("FAIL ovf_port0_kept: got %h expected %h", port_hex(0), exp_hex(37)); end
  endtask

  task automatic test_pending;
    logic [31:0] r;
    int e;
    bit seen12;
    exp_t x;
    seen12 = 1'b0;
    do_write(8'h40, 32'd12);
    sb_q.push_back('{0, exp_hex(12)});
    e = 0;
    repeat (2) begin
      @(negedge clk); e++;
      if (port_hex(0) === exp_hex(12)) seen12 = 1'b1;
    end
    do_write(8'h40, 32'd45);
    e++;
    // The earlier value is superseded and must never reach the display.
    void'(sb_q.pop_back());
    sb_q.push_back('{0, exp_hex(45)});
    do_read(8'h40, r); checks++; if (r !== 32'd45) begin errors++; $display("FAIL pend_readback: got %0d expected 45", r); end
    while (busy[0] === 1'b1 && e < 60) begin
      @(negedge clk); e++;
      if (port_hex(0) === exp_hex(12)) seen12 = 1'b1;
    end
    x = sb_q.pop_front();
    checks++; if (e !== 16) begin errors++; $display("FAIL pend_latency: got busy drop at %0d expected 16", e); end
    checks++; if (seen12 !== 1'b0) begin errors++; $display("FAIL pend_stale_shown: got %b expected 0", seen12); end
    checks++; if (port_hex(x.port) !== x.hex) begin errors++; $display("FAIL pend_hex45: got %h expected %h", port_hex(x.port), x.hex); end
  endtask

  task automatic test_done_collision;
    int e;
    bit dropped;
    exp_t x;
    dropped = 1'b0;
    do_write(8'h40, 32'd9);
    sb_q.push_back('{0, exp_hex(81)});
    e = 0;
    while (e < 7) begin
      @(negedge clk); e++;
      if (busy[0] !== 1'b1) dropped = 1'b1;
    end
    // This write lands on the DONE edge of the first conversion.
    do_write(8'h40, 32'd81);
    e++;
    if (busy[0] !== 1'b1) dropped = 1'b1;
    checks++; if (port_hex(0) !== exp_hex(45)) begin errors++; $display("FAIL coll_hex_held: got %h expected %h", port_hex(0), exp_hex(45)); end
    wait_idle(0, e, 60, e);
    x = sb_q.pop_front();
    checks++; if (dropped !== 1'b0) begin errors++; $display("FAIL coll_busy_gap: got %b expected 0", dropped); end
    checks++; if (e !== 16) begin errors++; $display("FAIL coll_latency: got %0d edges expected 16", e); end
    checks++; if (port_hex(x.port) !== x.hex) begin errors++; $display("FAIL coll_hex81: got %h expected %h", port_hex(x.port), x.hex); end
  endtask

  task automatic test_back_to_back;
    int e;
    exp_t x;
    do_write(8'h40, 32'd64);
    sb_q.push_back('{0, exp_hex(64)});
    do_write(8'h48, 32'd99);
    sb_q.push_back('{2, exp_hex(99)});
    checks++; if (busy !== 3'b101) begin errors++; $display("FAIL b2b_busy: got %b expected 101", busy); end
    wait_idle(0, 1, 40, e);
    x = sb_q.pop_front();
    checks++; if (e !== 8 || x.port !== 0) begin errors++; $display("FAIL b2b_p0_latency: got %0d edges expected 8", e); end
    checks++; if (port_hex(0) !== x.hex) begin errors++; $display("FAIL b2b_p0_hex: got %h expected %h", port_hex(0), x.hex); end
    wait_idle(2, e, 40, e);
    x = sb_q.pop_front();
    checks++; if (e !== 9 || x.port !== 2) begin errors++; $display("FAIL b2b_p2_latency: got %0d edges expected 9", e); end
    checks++; if (port_hex(2) !== x.hex) begin errors++; $display("FAIL b2b_p2_hex: got %h expected %h", port_hex(2), x.hex); end
  endtask

  task automatic test_ignored_writes;
    logic [31:0] r;
    do_write(8'h00, 32'h1F);
    do_write(8'h4C, 32'd7);
    io_sel = 1'b0; io_we = 1'b1; io_addr = 8'h40; io_wdata = 32'd11;
    @(negedge clk);
    io_we = 1'b0; io_wdata = 32'd0;
    checks++; if (busy !== 3'b000) begin errors++; $display("FAIL ign_busy: got %b expected 000", busy); end
    do_read(8'h40, r); checks++; if (r !== 32'd64) begin errors++; $display("FAIL ign_rd40: got %0d expected 64", r); end
    do_read(8'h00, r); checks++; if (r !== 32'd0) begin errors++; $display("FAIL ign_rd00: got %0h expected 0", r); end
    do_read(8'h4C, r); checks++; if (r !== 32'd0) begin errors++; $display("FAIL ign_rd4c: got %0h expected 0", r); end
    do_read(8'h08, r); checks++; if (r !== 32'd0) begin errors++; $display("FAIL ign_rd08: got %0h expected 0", r); end
  endtask

  task automatic test_switch;
    logic [31:0] r;
    logic [31:0] r5;
    int bad;
    io_addr = 8'h00;
    sw[4:0] = 5'b10101;
    r5 = 32'hFFFF_FFFF;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      do_read(8'h00, r);
      if (k == 5) r5 = r;
    end
    checks++; if (r5 !== 32'd0) begin errors++; $display("FAIL sw_early: got %0h expected 0", r5); end
    checks++; if (r !== 32'h15) begin errors++; $display("FAIL sw_settle: got %0h expected 15", r); end
    sw[4:0] = 5'b11111;
    repeat (2) @(negedge clk);
    sw[4:0] = 5'b10101;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      do_read(8'h00, r);
      if (r !== 32'h15) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL sw_glitch: got %0d changed reads expected 0", bad); end
    do_read(8'h04, r); checks++; if (r !== 32'd0) begin errors++; $display("FAIL sw_port1: got %0h expected 0", r); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] r;
    do_write(8'h48, 32'd55);
    repeat (2) @(negedge clk);
    checks++; if (busy[2] !== 1'b1) begin errors++; $display("FAIL rmid_busy_pre: got %b expected 1", busy[2]); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 3'b000) begin errors++; $display("FAIL rmid_busy: got %b expected 000", busy); end
    checks++; if (hex !== {6{7'b1000000}}) begin errors++; $display("FAIL rmid_hex: got %h expected %h", hex, {6{7'b1000000}}); end
    do_read(8'h48, r); checks++; if (r !== 32'd0) begin errors++; $display("FAIL rmid_rd48: got %0h expected 0", r); end
    do_read(8'h40, r); checks++; if (r !== 32'd0) begin errors++; $display("FAIL rmid_rd40: got %0h expected 0", r); end
    do_read(8'h7C, r); checks++; if (r !== 32'd0) begin errors++; $display("FAIL rmid_rd7c: got %0h expected 0", r); end
    do_read(8'h3C, r); checks++; if (r !== 32'd0) begin errors++; $display("FAIL rmid_rd3c: got %0h expected 0", r); end
    do_read(8'h00, r); checks++; if (r !== 32'd0) begin errors++; $display("FAIL rmid_rd00: got %0h expected 0", r); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_convert();
    test_overflow();
    test_pending();
    test_done_collision();
    test_back_to_back();
    test_ignored_writes();
    test_switch();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
